// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: buttons, digit-chain feedback and strobes between a host and timer_ctrl.
// master: host/digit-chain side. slave: timer_ctrl side.
interface timer_ctrl_if;
  logic        btn_start;
  logic        btn_pause;
  logic        btn_clear;
  logic [15:0] digits;
  logic        count_en;
  logic        load_en;
  logic        alarm;
  logic [1:0]  state;

  modport master (
    output btn_start, btn_pause, btn_clear, digits,
    input  count_en, load_en, alarm, state
  );

  modport slave (
    input  btn_start, btn_pause, btn_clear, digits,
    output count_en, load_en, alarm, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: countdown sequencing FSM driving an external BCD digit chain.
// Build option: define TIMER_ALARM_BLINK_EN to make alarm blink at the tick
// rate in DONE; otherwise alarm is steady and the prescaler parks at 0.
//
// state | meaning
// IDLE  | stopped; waits for start with a nonzero digit value
// RUN   | prescaler running; count_en strobes once per tick
// PAUSE | prescaler phase held; start or pause resumes
// DONE  | digits reached zero; alarm active until clear
module timer_ctrl #(
  parameter int TICK_DIV = 100000000
) (
  input logic         clk,
  input logic         rst,
  timer_ctrl_if.slave ctrl
);

  localparam logic [1:0] LP_IDLE  = 2'd0;
  localparam logic [1:0] LP_RUN   = 2'd1;
  localparam logic [1:0] LP_PAUSE = 2'd2;
  localparam logic [1:0] LP_DONE  = 2'd3;

  localparam int               LP_PW        = $clog2(TICK_DIV);
  localparam logic [LP_PW-1:0] LP_PRESC_MAX = LP_PW'(TICK_DIV - 1);

  logic [1:0]       r_state;
  logic [LP_PW-1:0] r_presc;
  logic             r_count_en;
  logic             r_load_en;
  logic             r_alarm;

  logic [1:0]       w_state_nxt;
  logic [LP_PW-1:0] w_presc_nxt;
  logic             w_count_en_nxt;
  logic             w_load_en_nxt;
  logic             w_alarm_nxt;

  logic             w_digits_zero;
  logic             w_wrap;
  logic [LP_PW-1:0] w_presc_step;

  assign w_digits_zero = (ctrl.digits == 16'h0000);
  assign w_wrap        = (r_presc == LP_PRESC_MAX);
  assign w_presc_step  = w_wrap ? '0 : r_presc + 1'b1;

  // Next-state decode; clear overrides everything, then per-state requests.
  always_comb begin
    w_state_nxt    = r_state;
    w_presc_nxt    = r_presc;
    w_count_en_nxt = 1'b0;
    w_load_en_nxt  = 1'b0;
    w_alarm_nxt    = r_alarm;

    if (ctrl.btn_clear) begin
      w_state_nxt   = LP_IDLE;
      w_presc_nxt   = '0;
      w_load_en_nxt = 1'b1;
      w_alarm_nxt   = 1'b0;
    end else begin
      case (r_state)
        LP_IDLE: begin
          if (ctrl.btn_start && !w_digits_zero) begin
            w_state_nxt = LP_RUN;
            w_presc_nxt = '0;
          end
        end

        LP_RUN: begin
          // The prescaler advances even on the pause cycle, so a tick that
          // coincides with pause is lost rather than replayed on resume.
          w_presc_nxt    = w_presc_step;
          w_count_en_nxt = w_wrap && !w_digits_zero && !ctrl.btn_pause;
          if (ctrl.btn_pause && !ctrl.btn_start) begin
            w_state_nxt = LP_PAUSE;
          end else if (w_digits_zero && !r_count_en) begin
            // Waiting one cycle past count_en lets the chain's last decrement land.
            w_state_nxt = LP_DONE;
            w_presc_nxt = '0;
            w_alarm_nxt = 1'b1;
          end
        end

        LP_PAUSE: begin
          if (ctrl.btn_start || ctrl.btn_pause) begin
            w_state_nxt = LP_RUN;
          end
        end

        LP_DONE: begin
`ifdef TIMER_ALARM_BLINK_EN
          w_presc_nxt = w_presc_step;
          if (w_wrap) begin
            w_alarm_nxt = !r_alarm;
          end
`else
          w_presc_nxt = '0;
          w_alarm_nxt = 1'b1;
`endif
        end

        default: begin
          w_state_nxt = LP_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers; reset wins over all buttons and never loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LP_IDLE;
      r_presc    <= '0;
      r_count_en <= 1'b0;
      r_load_en  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_count_en <= w_count_en_nxt;
      r_load_en  <= w_load_en_nxt;
      r_alarm    <= w_alarm_nxt;
    end
  end

  assign ctrl.state    = r_state;
  assign ctrl.count_en = r_count_en;
  assign ctrl.load_en  = r_load_en;
  assign ctrl.alarm    = r_alarm;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized buttons against a
// cycle-level behavioural model; the bench also plays the BCD digit chain
// (MM:SS, kept as a plain seconds count) driven by the model's strobes.
`timescale 1ns/1ps
module tb_timer_ctrl;
  localparam int TD      = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  timer_ctrl_if ifc();

  timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model
  int m_state = S_IDLE;
  int m_phase = 0;
  bit m_ce    = 1'b0;
  bit m_ld    = 1'b0;
  bit m_alarm = 1'b0;
  int chain_s  = 0;
  int preset_s = 0;
  int presets[7] = '{0, 1, 2, 3, 5, 60, 61};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mn, sc;
    mn = s / 60;
    sc = s % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // One clock of the reference behaviour, using pre-edge inputs and digits.
  task automatic model_update(input bit r, input bit c, input bit s, input bit p);
    bit dz, old_ce, old_ld;
    int nst, nph;
    bit nce, nld, nal;
    dz = (chain_s == 0);
    old_ce = m_ce; old_ld = m_ld;
    nst = m_state; nph = m_phase; nce = 1'b0; nld = 1'b0; nal = m_alarm;
    if (r) begin
      nst = S_IDLE; nph = 0; nal = 1'b0;
    end else if (c) begin
      nst = S_IDLE; nph = 0; nld = 1'b1; nal = 1'b0;
    end else if (m_state == S_IDLE) begin
      if (s && !dz) begin nst = S_RUN; nph = 0; end
    end else if (m_state == S_RUN) begin
      nce = (m_phase == TD - 1) && !dz && !p;
      nph = (m_phase + 1) % TD;
      if (p && !s) nst = S_PAUSE;
      else if (dz && !old_ce) begin nst = S_DONE; nph = 0; nal = 1'b1; end
    end else if (m_state == S_PAUSE) begin
      if (s || p) nst = S_RUN;
    end else begin
`ifdef TIMER_ALARM_BLINK_EN
      if (m_phase == TD - 1) nal = !m_alarm;
      nph = (m_phase + 1) % TD;
`else
      nph = 0; nal = 1'b1;
`endif
    end
    m_state = nst; m_phase = nph; m_ce = nce; m_ld = nld; m_alarm = nal;
    if (r || old_ld) chain_s = preset_s;
    else if (old_ce && chain_s > 0) chain_s = chain_s - 1;
  endtask

  // Called at a negedge: apply buttons over one rising edge, then compare.
  task automatic step(input bit r, input bit c, input bit s, input bit p);
    rst = r; ifc.btn_clear = c; ifc.btn_start = s; ifc.btn_pause = p;
    @(posedge clk);
    #1;
    model_update(r, c, s, p);
    rst = 1'b0; ifc.btn_clear = 1'b0; ifc.btn_start = 1'b0; ifc.btn_pause = 1'b0;
    ifc.digits = to_bcd(chain_s);
    @(negedge clk);
    check("state",    32'(ifc.state),    32'(m_state));
    check("count_en", 32'(ifc.count_en), 32'(m_ce));
    check("load_en",  32'(ifc.load_en),  32'(m_ld));
    check("alarm",    32'(ifc.alarm),    32'(m_alarm));
  endtask

  initial begin
    int npulse, t1, t2, t3, tdone, ncyc, nce;
    logic [11:0] pat;
    logic [11:0] pat_exp;
    bit seen;
    ifc.btn_start = 1'b0; ifc.btn_pause = 1'b0; ifc.btn_clear = 1'b0;
    ifc.digits = 16'h0000;

    // reset, then count 3 seconds down to DONE
    preset_s = 3;
    step(1, 0, 1, 1);
    step(1, 0, 0, 0);
    check("rst_state", 32'(ifc.state), 32'(S_IDLE));
    check("rst_digits", 32'(ifc.digits), 32'h0003);
    step(0, 0, 1, 0);
    check("start_run", 32'(ifc.state), 32'(S_RUN));
    npulse = 0; t1 = 0; t2 = 0; t3 = 0; tdone = -1;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0);
      if (ifc.count_en) begin
        npulse++;
        if (npulse == 1) t1 = i;
        if (npulse == 2) t2 = i;
        if (npulse == 3) t3 = i;
      end
      if (ifc.state == 2'd3) begin tdone = i; break; end
    end
    check("done_timeout", 32'(tdone > 0), 32'd1);
    check("pulse_count", 32'(npulse), 32'd3);
    check("first_pulse", 32'(t1), 32'd4);
    check("pulse_period", 32'(t2 - t1), 32'd4);
    check("done_latency", 32'(tdone - t3), 32'd2);

    // alarm pattern in DONE, with ignored start/pause presses
    pat = {11'd0, ifc.alarm};
    for (int i = 1; i < 12; i++) begin
      step(0, 0, i == 3, i == 6);
      pat = {pat[10:0], ifc.alarm};
    end
`ifdef TIMER_ALARM_BLINK_EN
    pat_exp = 12'b1111_0000_1111;
`else
    pat_exp = 12'b1111_1111_1111;
`endif
    check("alarm_pattern", 32'(pat), 32'(pat_exp));
    check("done_hold", 32'(ifc.state), 32'(S_DONE));
    step(0, 1, 0, 0);
    check("clear_alarm", 32'(ifc.alarm), 32'd0);
    check("clear_load", 32'(ifc.load_en), 32'd1);

    // start with zero digits is ignored
    preset_s = 0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    nce = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      nce += int'(ifc.count_en);
    end
    check("zero_idle", 32'(ifc.state), 32'(S_IDLE));
    check("zero_no_ce", 32'(nce), 32'd0);

    // pause exactly on the tick, resume 10 cycles later
    preset_s = 5;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 8 && !(m_state == S_RUN && m_phase == TD - 1); i++) step(0, 0, 0, 0);
    check("phase_reached", 32'(m_phase), 32'(TD - 1));
    step(0, 0, 0, 1);
    check("pause_state", 32'(ifc.state), 32'(S_PAUSE));
    check("pause_no_tick", 32'(ifc.count_en), 32'd0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("resume_run", 32'(ifc.state), 32'(S_RUN));
    ncyc = 1; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      ncyc++;
      if (ifc.count_en) begin seen = 1'b1; break; end
    end
    check("resume_tick_seen", 32'(seen), 32'd1);
    check("resume_latency", 32'(ncyc), 32'd5);

    // clear beats start in RUN
    step(0, 1, 1, 0);
    check("prio_state", 32'(ifc.state), 32'(S_IDLE));
    check("prio_load", 32'(ifc.load_en), 32'd1);
    check("prio_no_ce", 32'(ifc.count_en), 32'd0);

    // reset mid-PAUSE together with pause
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("pre_rst_pause", 32'(ifc.state), 32'(S_PAUSE));
    step(1, 0, 0, 1);
    check("rst_pause_state", 32'(ifc.state), 32'(S_IDLE));
    check("rst_pause_outs", 32'({ifc.count_en, ifc.load_en, ifc.alarm}), 32'd0);
    step(0, 0, 0, 0);
    check("rst_no_load", 32'(ifc.load_en), 32'd0);

    // randomized buttons
    for (int i = 0; i < 3000; i++) begin
      int x;
      bit r, c, s, p;
      x = int'($urandom_range(0, 99));
      r = ($urandom_range(0, 199) == 0);
      c = (x < 3);
      s = (x >= 3 && x < 15) || (c && $urandom_range(0, 1) == 1);
      p = (x >= 15 && x < 25);
      if (c || r) preset_s = presets[$urandom_range(0, 6)];
      step(r, c, s, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 100000000, clk cycles per count tick; legal range 2 and above.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: btn_start  input  1  start/resume request, one-cycle pulse.
REQ-005 Port: btn_pause  input  1  pause/resume toggle request, one-cycle pulse.
REQ-006 Port: btn_clear  input  1  abort and reload request, one-cycle pulse.
REQ-007 Port: digits  input  16  current BCD digit-chain value {min_tens, min_ones, sec_tens, sec_ones}, fed back from the downstream digit counters.
REQ-008 Port: count_en  output  1  one-cycle decrement strobe to the digit chain.
REQ-009 Port: load_en  output  1  one-cycle strobe that makes the digit chain load its preset.
REQ-010 Port: alarm  output  1  expiry indication.
REQ-011 Port: state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-012 FSM SHALL have four states: IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-013 Request priority SHALL be btn_clear over btn_start over btn_pause when pulses coincide.
REQ-014 btn_clear in any state SHALL go to IDLE, pulse load_en for exactly one cycle, and clear alarm and prescaler.
REQ-015 IDLE + btn_start with digits != 0 SHALL go to RUN with prescaler = 0; with digits == 0, btn_start SHALL be ignored.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, advancing only in RUN (and in DONE under REQ-026); it SHALL hold its value in PAUSE.
REQ-017 count_en SHALL assert for exactly one cycle, the cycle after the prescaler equals TICK_DIV-1 in RUN with digits != 0 and no btn_pause/btn_clear that cycle.
REQ-018 RUN + btn_pause SHALL go to PAUSE; the tick coinciding with btn_pause SHALL be suppressed and not deferred.
REQ-019 RUN + btn_start SHALL be ignored.
REQ-020 PAUSE + btn_start or btn_pause SHALL return to RUN, resuming from the held prescaler value.
REQ-021 RUN with digits == 0 and count_en low SHALL go to DONE next cycle; DONE entry SHALL occur 2 cycles after the count_en pulse that reached zero.
REQ-022 DONE SHALL assert alarm and ignore btn_start/btn_pause; only btn_clear or rst leaves DONE.
REQ-023 count_en SHALL never assert outside RUN; load_en SHALL never assert except per REQ-014.

Reset
REQ-024 On rst high at a clk edge: state = IDLE, prescaler = 0, count_en = 0, load_en = 0, alarm = 0; rst SHALL override all button inputs.
REQ-025 rst mid-RUN SHALL discard the prescaler phase; it SHALL NOT pulse load_en, since the digit chain has its own reset.

Configuration
REQ-026 Macro TIMER_ALARM_BLINK_EN defined: in DONE the prescaler SHALL run, and alarm SHALL go high on entry and toggle on every prescaler wrap.
REQ-027 Macro TIMER_ALARM_BLINK_EN undefined: alarm SHALL be steady high throughout DONE, and the prescaler SHALL hold at 0 in DONE.

Verification (TICK_DIV=4)
REQ-028 rst, then btn_start with digits=16'h0003 -> state=RUN; count_en pulses every 4 cycles; bench decrements digits to 0 -> DONE 2 cycles after the third pulse, alarm=1.
REQ-029 btn_start with digits=16'h0000 -> state stays IDLE; no count_en.
REQ-030 RUN, btn_pause at prescaler=3 -> no count_en that period; state=PAUSE; btn_start 10 cycles later -> RUN, first count_en 1 cycle after prescaler reaches 3 again (~5 cycles).
REQ-031 Same cycle btn_clear+btn_start in RUN -> state=IDLE, load_en one cycle, no count_en.
REQ-032 DONE with TIMER_ALARM_BLINK_EN -> alarm pattern 1111 0000 1111; without macro -> alarm steady 1; btn_clear -> alarm=0 next cycle.
REQ-033 rst asserted mid-PAUSE together with btn_pause -> state=IDLE, all outputs 0, load_en not pulsed.
